// File: rtl/ser_word_rx.sv
// ser_word_rx: serial-in/parallel-out frame receiver.
// Assembles WIDTH bits strobed by EN into a word, shifting in the direction
// latched at START, and reports restart-mid-frame and inter-bit timeouts.
module ser_word_rx #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned TW      = 16
) (
  input  logic             CP,
  input  logic             CR_n,
  input  logic             START,
  input  logic             DIR,
  input  logic             EN,
  input  logic             DS,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             BUSY,
  output logic             ERR
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nx;
  logic [WIDTH-1:0] sh_shift;
  logic [WIDTH-1:0] q_nx;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_nx;
  logic [TW-1:0]    idle_cnt;
  logic [TW-1:0]    idle_cnt_nx;
  logic             dir_q;
  logic             dir_nx;
  logic             valid_nx;
  logic             err_nx;
  logic             last_bit;
  logic             timeout_hit;

  // Shift candidate in the latched direction, plus completion/timeout decodes
  always_comb begin
    if (dir_q) begin
      sh_shift = {DS, sh[WIDTH-1:1]};
    end else begin
      sh_shift = {sh[WIDTH-2:0], DS};
    end
    last_bit    = EN && (bit_cnt == CW'(WIDTH - 1));
    timeout_hit = (TIMEOUT != 0) && !EN && !START &&
                  (idle_cnt == TW'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge CP) begin
    if (!CR_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; START on the completion edge keeps us in RECV
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nx = S_RECV;
        end
      end
      S_RECV: begin
        if (START) begin
          state_nx = S_RECV;
        end else if (last_bit || timeout_hit) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and output next values; Q only changes on completion
  always_comb begin
    sh_nx       = sh;
    bit_cnt_nx  = bit_cnt;
    idle_cnt_nx = idle_cnt;
    dir_nx      = dir_q;
    q_nx        = Q;
    valid_nx    = 1'b0;
    err_nx      = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          sh_nx       = '0;
          bit_cnt_nx  = '0;
          idle_cnt_nx = '0;
          dir_nx      = DIR;
        end
      end
      S_RECV: begin
        if (last_bit) begin
          // Word done; a coincident START begins the next frame cleanly
          q_nx        = sh_shift;
          valid_nx    = 1'b1;
          sh_nx       = '0;
          bit_cnt_nx  = '0;
          idle_cnt_nx = '0;
          if (START) begin
            dir_nx = DIR;
          end
        end else if (START) begin
          // Restart mid-frame: flag it and drop any bit on this edge
          err_nx      = 1'b1;
          sh_nx       = '0;
          bit_cnt_nx  = '0;
          idle_cnt_nx = '0;
          dir_nx      = DIR;
        end else if (EN) begin
          sh_nx       = sh_shift;
          bit_cnt_nx  = bit_cnt + CW'(1);
          idle_cnt_nx = '0;
        end else if (timeout_hit) begin
          err_nx      = 1'b1;
          sh_nx       = '0;
          bit_cnt_nx  = '0;
          idle_cnt_nx = '0;
        end else if (TIMEOUT != 0) begin
          idle_cnt_nx = idle_cnt + TW'(1);
        end
      end
      default: begin
        sh_nx       = '0;
        bit_cnt_nx  = '0;
        idle_cnt_nx = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CP) begin
    if (!CR_n) begin
      sh       <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      dir_q    <= 1'b0;
      Q        <= '0;
      VALID    <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      sh       <= sh_nx;
      bit_cnt  <= bit_cnt_nx;
      idle_cnt <= idle_cnt_nx;
      dir_q    <= dir_nx;
      Q        <= q_nx;
      VALID    <= valid_nx;
      ERR      <= err_nx;
      BUSY     <= (state_nx == S_RECV);
    end
  end

endmodule

// File: tb/tb_ser_word_rx.sv
// tb_ser_word_rx: directed frames with a scoreboard of expected VALID/ERR events.
module tb_ser_word_rx;

  logic       CP;
  logic       CR_n;
  logic       START;
  logic       DIR;
  logic       EN;
  logic       DS;
  logic [3:0] Q;
  logic       VALID;
  logic       BUSY;
  logic       ERR;

  typedef struct packed {
    logic       is_err;
    logic [3:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ser_word_rx #(.WIDTH(4), .TIMEOUT(8), .TW(16)) dut (
    .CP(CP), .CR_n(CR_n), .START(START), .DIR(DIR), .EN(EN), .DS(DS),
    .Q(Q), .VALID(VALID), .BUSY(BUSY), .ERR(ERR)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given inputs; returns 1 time unit after the edge
  task automatic cyc(input logic st, input logic dir, input logic en, input logic ds);
    START = st; DIR = dir; EN = en; DS = ds;
    @(posedge CP);
    #1;
  endtask

  task automatic push(input logic is_err, input logic [3:0] q);
    exp_t e;
    e.is_err = is_err;
    e.q      = q;
    exp_q.push_back(e);
  endtask

  // Monitor: every VALID/ERR pulse must match the oldest expectation
  always @(negedge CP) begin
    if (VALID === 1'b1 || ERR === 1'b1) begin
      exp_t e;
      check("valid_err_exclusive", {3'b0, VALID & ERR}, 4'b0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got VALID=%b ERR=%b Q=%b expected no event at %0t",
                 VALID, ERR, Q, $time);
      end else begin
        e = exp_q.pop_front();
        check(e.is_err ? "err_pulse" : "valid_pulse", {3'b0, ERR}, {3'b0, e.is_err});
        check(e.is_err ? "q_on_err" : "q_on_valid", Q, e.q);
      end
    end
  end

  initial begin
    logic [3:0] bits;
    CR_n = 1'b0; START = 1'b0; DIR = 1'b0; EN = 1'b0; DS = 1'b0;

    // Reset overrides START/EN
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      check("rst_q", Q, 4'b0000);
      check("rst_flags", {1'b0, VALID, BUSY, ERR}, 4'b0000);
    end
    CR_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("idle_after_rst", {3'b0, BUSY}, 4'b0);

    // DIR=0, bits 1,1,0,1 -> 1101
    bits = 4'b1101;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("busy_after_start", {3'b0, BUSY}, 4'b1);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) push(1'b0, 4'b1101);
      cyc(1'b0, 1'b0, 1'b1, bits[i]);
    end
    check("busy_fall_r", {3'b0, BUSY}, 4'b0);

    // DIR=1, same bits -> 1011
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) push(1'b0, 4'b1011);
      cyc(1'b0, 1'b1, 1'b1, bits[i]);
    end
    check("busy_fall_l", {3'b0, BUSY}, 4'b0);

    // 3-cycle gaps, DIR toggled mid-frame (latched DIR=0) -> 1101
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      repeat (3) cyc(1'b0, 1'(i % 2), 1'b0, 1'b0);
      if (i == 0) push(1'b0, 4'b1101);
      cyc(1'b0, 1'((i + 1) % 2), 1'b1, bits[i]);
    end

    // Restart: bits 1,0, START again (EN=1 discarded), then 0,1,1,1 -> 0111
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b1, 4'b1101);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("busy_on_restart", {3'b0, BUSY}, 4'b1);
    bits = 4'b0111;
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) push(1'b0, 4'b0111);
      cyc(1'b0, 1'b0, 1'b1, bits[i]);
    end

    // Timeout after one bit and 8 idle edges; Q keeps 0111
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push(1'b1, 4'b0111);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 7) check("busy_idle7", {3'b0, BUSY}, 4'b1);
    end
    check("busy_timeout", {3'b0, BUSY}, 4'b0);
    check("q_after_timeout", Q, 4'b0111);

    // Back-to-back: START with 4th bit of 1101, then 0,0,1,0 -> 0010
    bits = 4'b1101;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i >= 1; i--) cyc(1'b0, 1'b0, 1'b1, bits[i]);
    push(1'b0, 4'b1101);
    cyc(1'b1, 1'b0, 1'b1, bits[0]);
    check("busy_b2b", {3'b0, BUSY}, 4'b1);
    bits = 4'b0010;
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) push(1'b0, 4'b0010);
      cyc(1'b0, 1'b0, 1'b1, bits[i]);
    end
    check("busy_b2b_end", {3'b0, BUSY}, 4'b0);

    // Reset after 2 bits, then a normal frame 1011
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    CR_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("busy_mid_rst", {3'b0, BUSY}, 4'b0);
    check("q_mid_rst", Q, 4'b0000);
    CR_n = 1'b1;
    bits = 4'b1011;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) push(1'b0, 4'b1011);
      cyc(1'b0, 1'b0, 1'b1, bits[i]);
    end

    // Drain and confirm every expected event was seen
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("scoreboard_empty", 4'(exp_q.size()), 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
